// File: rtl/v68k_alu_if.sv
// v68k_alu_if: operand/result bundle between the execution sequencer and the ALU.
//   a, b   : operands (a is the destination operand for SUB/SUBX)
//   op     : operation select
//   x      : extend bit, held by the sequencer
//   o      : registered result
//   c,z,v,n: registered condition codes
// The slave modport is the ALU side. The master modport is the sequencer side.
interface v68k_alu_if #(
    parameter int bits = 16
);
    logic [bits-1:0] a;
    logic [bits-1:0] b;
    logic [2:0]      op;
    logic            x;
    logic [bits-1:0] o;
    logic            c;
    logic            z;
    logic            v;
    logic            n;

    modport master (
        output a, b, op, x,
        input  o, c, z, v, n
    );

    modport slave (
        input  a, b, op, x,
        output o, c, z, v, n
    );
endinterface

// File: rtl/v68k_alu.sv
// v68k_alu: 68000-style integer ALU with registered result and CZVN flags.
//   clk     : system clock, rising-edge active
//   reset_n : asynchronous active-low reset; clears the result and all flags
//   alu     : v68k_alu_if slave (a, b, op, x in; o, c, z, v, n out)
// Operations are ADD, ADDX, SUB, SUBX, AND, OR, EOR and NOT.
// The result is available one clock after the operands are presented, and the
// ALU accepts one operation per cycle.
module v68k_alu #(
    parameter int bits = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    v68k_alu_if.slave  alu
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDX = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SUBX = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_EOR  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    logic [bits-1:0] o_q, o_d;
    logic            c_q, c_d;
    logic            z_q, z_d;
    logic            v_q, v_d;
    logic            n_q, n_d;

    logic [bits:0]   ext_a, ext_b, ext_x, arith;
    logic            is_add, is_sub, is_ext;
    logic            a_msb, b_msb, r_msb;

    always_comb begin
        ext_a  = {1'b0, alu.a};
        ext_b  = {1'b0, alu.b};
        ext_x  = {{bits{1'b0}}, alu.x};
        is_add = (alu.op == OP_ADD) || (alu.op == OP_ADDX);
        is_sub = (alu.op == OP_SUB) || (alu.op == OP_SUBX);
        is_ext = (alu.op == OP_ADDX) || (alu.op == OP_SUBX);

        // The extra top bit is the carry out for adds. For subtracts it is the
        // borrow, because a-b-x goes negative exactly when a < b+x.
        arith = '0;
        unique case (alu.op)
            OP_ADD:  arith = ext_a + ext_b;
            OP_ADDX: arith = ext_a + ext_b + ext_x;
            OP_SUB:  arith = ext_a - ext_b;
            OP_SUBX: arith = ext_a - ext_b - ext_x;
            default: arith = '0;
        endcase

        o_d = '0;
        c_d = 1'b0;
        unique case (alu.op)
            OP_ADD, OP_ADDX, OP_SUB, OP_SUBX: begin
                o_d = arith[bits-1:0];
                c_d = arith[bits];
            end
            OP_AND:  o_d = alu.a & alu.b;
            OP_OR:   o_d = alu.a | alu.b;
            OP_EOR:  o_d = alu.a ^ alu.b;
            OP_NOT:  o_d = ~alu.a;
            default: o_d = '0;
        endcase

        a_msb = alu.a[bits-1];
        b_msb = alu.b[bits-1];
        r_msb = o_d[bits-1];

        v_d = 1'b0;
        if (is_add) begin
            v_d = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (is_sub) begin
            v_d = (a_msb != b_msb) && (r_msb != a_msb);
        end

        // ADDX/SUBX keep Z sticky so a multi-precision chain reports zero
        // only when every word of the chain was zero.
        if (is_ext) begin
            z_d = z_q & (o_d == '0);
        end else begin
            z_d = (o_d == '0);
        end

        n_d = r_msb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q <= '0;
            c_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            o_q <= o_d;
            c_q <= c_d;
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign alu.o = o_q;
    assign alu.c = c_q;
    assign alu.z = z_q;
    assign alu.v = v_q;
    assign alu.n = n_q;
endmodule

// File: tb/tb_v68k_alu.sv
module tb_v68k_alu;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] o;
        logic         c, z, v, n;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    v68k_alu_if #(.bits(W)) bus ();

    v68k_alu #(.bits(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .alu     (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   op_id  = 0;
    bit   z_m    = 1'b0;

    // Reference model: plain integer arithmetic on unsigned and signed values.
    task automatic model(input int op, input int a, input int b, input int x,
                         output exp_t e);
        int mask, res, xx, sa, sb, sres;
        mask = (1 << W) - 1;
        sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        xx   = (op == 1 || op == 3) ? x : 0;
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (op)
            0, 1: begin
                res  = a + b + xx;
                e.c  = (res > mask);
                sres = sa + sb + xx;
                e.v  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
            end
            2, 3: begin
                res  = a - b - xx;
                e.c  = (a < b + xx);
                sres = sa - sb - xx;
                e.v  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
            end
            4:       res = a & b;
            5:       res = a | b;
            6:       res = a ^ b;
            default: res = ~a;
        endcase
        res = res & mask;
        e.o = res[W-1:0];
        e.n = (res >= (1 << (W - 1)));
        if (op == 1 || op == 3) z_m = z_m && (res == 0);
        else                    z_m = (res == 0);
        e.z  = z_m;
        e.id = op_id;
    endtask

    task automatic do_op(input int op, input int a, input int b, input int x);
        exp_t e;
        @(negedge clk);
        bus.op = op[2:0];
        bus.a  = a[W-1:0];
        bus.b  = b[W-1:0];
        bus.x  = x[0];
        model(op, a, b, x, e);
        exp_q.push_back(e);
        op_id++;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.o !== '0 || bus.c !== 1'b0 || bus.z !== 1'b0 ||
            bus.v !== 1'b0 || bus.n !== 1'b0) begin
            errors++;
            $display("FAIL %s: got o=%h c=%b z=%b v=%b n=%b, want all zero",
                     name, bus.o, bus.c, bus.z, bus.v, bus.n);
        end
    endtask

    // Monitor: every capturing edge presents a result; compare against the
    // oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (reset_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.o !== e.o || bus.c !== e.c || bus.z !== e.z ||
                bus.v !== e.v || bus.n !== e.n) begin
                errors++;
                $display("FAIL op#%0d: got o=%h c=%b z=%b v=%b n=%b, want o=%h c=%b z=%b v=%b n=%b",
                         e.id, bus.o, bus.c, bus.z, bus.v, bus.n,
                         e.o, e.c, e.z, e.v, e.n);
            end
        end
    end

    // Directed vectors: op, a, b, x
    int dir_tab[][4] = '{
        '{0, 'h0000, 'h0000, 0}, '{0, 'h010F, 'h010F, 0},
        '{0, 'h7FFF, 'h0001, 0}, '{0, 'hFFFF, 'h0001, 0},
        '{0, 'hFFFF, 'hFFFF, 0}, '{0, 'h8000, 'hFFFF, 0},
        '{0, 'hFFFF, 'h1000, 1}, '{2, 'h0000, 'h0001, 1},
        '{2, 'h8000, 'h0001, 0}, '{3, 'h0005, 'h0005, 1},
        '{1, 'hFFFF, 'hFFFF, 1}, '{3, 'h0000, 'h0000, 1},
        '{0, 'h0000, 'h0000, 0}, '{1, 'h0000, 'h0000, 0},
        '{1, 'h0001, 'h0000, 0}, '{1, 'h0000, 'h0000, 0},
        '{4, 'hF0F0, 'hFF00, 1}, '{5, 'h0000, 'h0000, 0},
        '{6, 'hFFFF, 'hFFFF, 0}, '{7, 'h0000, 'h1234, 0},
        '{0, 'h0000, 'h0000, 0}, '{3, 'h0000, 'h0000, 0}
    };

    int edge_vals[6] = '{'h0000, 'h0001, 'h7FFF, 'h8000, 'hFFFE, 'hFFFF};

    initial begin
        bus.a  = '0;
        bus.b  = '0;
        bus.op = '0;
        bus.x  = 1'b0;
        #3;
        check_zero("reset_initial");
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset_held");
        @(negedge clk);
        reset_n = 1'b1;
        z_m = 1'b0;

        foreach (dir_tab[i]) do_op(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3]);

        // Mid-stream asynchronous reset, away from any clock edge.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("reset_async_mid");
        @(posedge clk);
        #2;
        check_zero("reset_mid_held");
        @(negedge clk);
        reset_n = 1'b1;
        z_m = 1'b0;

        // Z is clear after reset, so a sticky chain stays clear.
        do_op(1, 0, 0, 0);
        do_op(3, 0, 0, 0);
        do_op(2, 'h1234, 'h1234, 0);
        do_op(3, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            int a, b;
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : int'($urandom_range(0, 'hFFFF));
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : int'($urandom_range(0, 'hFFFF));
            do_op(int'($urandom_range(0, 7)), a, b, int'($urandom_range(0, 1)));
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
